// File: rtl/duty_ramp_ctrl_pkg.sv
// duty_ramp_ctrl_pkg: shared state encoding, default ceiling and the slew step helper
package duty_ramp_ctrl_pkg;
   localparam int MAX_DUTY_DEF = 100;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RAMP = 2'd1, S_STOP = 2'd2} state_e;
   // One slew step from cur toward tgt, 8 bits wide so the add/subtract never wraps
   function automatic logic [6:0] step_toward(input logic [6:0] cur, input logic [6:0] tgt, input logic [7:0] step);
      logic [7:0] c, t;
      c = {1'b0, cur};
      t = {1'b0, tgt};
      return 7'((t > c) ? ((t - c <= step) ? t : c + step) : ((c - t <= step) ? t : c - step));
   endfunction
endpackage

// File: rtl/duty_ramp_ctrl_tick_divider.sv
// tick_divider: counts en pulses and emits a one-cycle tick every DIV pulses
module tick_divider #(
   parameter int DIV = 1000,
   parameter int W   = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic tick
);
   logic [W-1:0] cnt_q, cnt_d;
   assign tick = en && !clear && (cnt_q == W'(DIV - 1));
   // next count: clear wins, then hold without en, wrap on tick
   always_comb cnt_d = clear ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
   // counter register
   always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/duty_ramp_ctrl.sv
// duty_ramp_ctrl: slews pwm duty toward a commanded target with estop override
module duty_ramp_ctrl
   import duty_ramp_ctrl_pkg::*;
#(
   parameter int RAMP_DIV = 1000,
   parameter int DIV_W    = 10,
   parameter int STEP     = 1,
   parameter int MAX_DUTY = MAX_DUTY_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       one_MHz_enable,
   input  logic       cmd_valid,
   input  logic [6:0] cmd_duty,
   output logic       cmd_ready,
   input  logic       estop,
   output logic [6:0] duty_cycle,
   output logic       at_target,
   output logic       busy
);
   state_e     state_q, state_d;
   logic [6:0] duty_q, duty_d, tgt_q, tgt_d, cmd_clamped, nxt;
   logic       rdy_q, accept, tick, clear;
   assign cmd_ready   = rdy_q && state_q != S_STOP;
   assign accept      = cmd_valid && cmd_ready;
   assign cmd_clamped = (cmd_duty > 7'(MAX_DUTY)) ? 7'(MAX_DUTY) : cmd_duty;
   assign clear       = estop || accept || state_q != S_RAMP;
   assign nxt         = step_toward(duty_q, tgt_q, 8'(STEP));
   assign duty_cycle  = duty_q;
   assign at_target   = duty_q == tgt_q && state_q != S_STOP;
   assign busy        = state_q == S_RAMP;
   tick_divider #(.DIV(RAMP_DIV), .W(DIV_W)) u_div (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .en    (one_MHz_enable),
      .tick  (tick)
   );
   // estop beats accept beats step; an accept swallows a coincident tick
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      tgt_d   = tgt_q;
      if (estop) begin
         state_d = S_STOP;
         duty_d  = '0;
         tgt_d   = '0;
      end else if (state_q == S_STOP) begin
         state_d = S_IDLE;
      end else if (accept) begin
         tgt_d   = cmd_clamped;
         state_d = (cmd_clamped != duty_q) ? S_RAMP : S_IDLE;
      end else if (tick) begin
         duty_d  = nxt;
         state_d = (nxt == tgt_q) ? S_IDLE : S_RAMP;
      end
   end
   // state, duty, target and ready-after-reset registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         duty_q  <= '0;
         tgt_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         tgt_q   <= tgt_d;
         rdy_q   <= 1'b1;
      end
   end
endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// tb_duty_ramp_ctrl: scoreboard bench, expected duty sequence queued per accepted command
module tb_duty_ramp_ctrl;
   localparam int RAMP_DIV = 2;
   localparam int STEP     = 5;
   localparam int MAXD     = 100;

   logic       clk = 0, reset = 1, one_MHz_enable = 0, cmd_valid = 0, estop = 0;
   logic [6:0] cmd_duty = '0;
   logic       cmd_ready, at_target, busy;
   logic [6:0] duty_cycle;

   int checks = 0, errors = 0;
   int exp_q[$];
   int m_duty = 0, pulses = 0, mon_e;
   bit m_rdy = 0, m_stop = 0, armed = 0;

   duty_ramp_ctrl #(.RAMP_DIV(RAMP_DIV), .DIV_W(2), .STEP(STEP), .MAX_DUTY(MAXD)) dut (
      .clk            (clk),
      .reset          (reset),
      .one_MHz_enable (one_MHz_enable),
      .cmd_valid      (cmd_valid),
      .cmd_duty       (cmd_duty),
      .cmd_ready      (cmd_ready),
      .estop          (estop),
      .duty_cycle     (duty_cycle),
      .at_target      (at_target),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   initial forever begin
      repeat (9) @(negedge clk);
      one_MHz_enable = 1;
      @(negedge clk);
      one_MHz_enable = 0;
   end

   initial forever begin
      @(posedge clk);
      if (one_MHz_enable) pulses++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (armed) begin
         if (int'(duty_cycle) != m_duty && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("duty_step", 32'(duty_cycle), mon_e);
            chk("step_pace", pulses, RAMP_DIV);
            m_duty = mon_e;
            pulses = 0;
         end else chk("duty_hold", 32'(duty_cycle), m_duty);
         chk("busy", 32'(busy), 32'(exp_q.size() != 0));
         chk("at_target", 32'(at_target), 32'(!m_stop && exp_q.size() == 0));
         chk("cmd_ready", 32'(cmd_ready), 32'(m_rdy && !m_stop));
      end
   end

   task automatic send(input int d);
      int t, v;
      @(negedge clk);
      cmd_valid = 1;
      cmd_duty  = 7'(d);
      @(posedge clk);
      #1;
      cmd_valid = 0;
      if (m_rdy && !m_stop && !estop) begin
         t = d > MAXD ? MAXD : d;
         v = m_duty;
         exp_q.delete();
         while (v != t) begin
            if (t > v) v = (t - v <= STEP) ? t : v + STEP;
            else       v = (v - t <= STEP) ? t : v - STEP;
            exp_q.push_back(v);
         end
         pulses = 0;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) chk("ramp_timeout", exp_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_duty(input int v, input int budget);
      int n = 0;
      while (m_duty != v && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (m_duty != v) chk("reach_timeout", m_duty, v);
   endtask

   task automatic do_estop(input int hold);
      @(negedge clk);
      estop = 1;
      cmd_valid = 1;
      cmd_duty = 7'd80;
      @(posedge clk);
      #1;
      exp_q.delete();
      m_duty = 0;
      m_stop = 1;
      repeat (hold) @(posedge clk);
      @(negedge clk);
      estop = 0;
      cmd_valid = 0;
      @(posedge clk);
      #1;
      m_stop = 0;
   endtask

   task automatic do_reset(input int cyc);
      @(negedge clk);
      reset = 1;
      @(posedge clk);
      #1;
      exp_q.delete();
      m_duty = 0;
      m_rdy = 0;
      m_stop = 0;
      repeat (cyc - 1) @(posedge clk);
      @(negedge clk);
      reset = 0;
      @(posedge clk);
      #1;
      m_rdy = 1;
   endtask

   initial begin
      repeat (10) @(posedge clk);
      #1;
      armed = 1;
      @(negedge clk);
      chk("rst_duty", 32'(duty_cycle), 0);
      chk("rst_ready_low", 32'(cmd_ready), 0);
      reset = 0;
      @(posedge clk);
      #1;
      m_rdy = 1;
      @(negedge clk);
      chk("ready_after_rst", 32'(cmd_ready), 1);
      send(50);
      @(negedge clk);
      chk("busy_after_cmd", 32'(busy), 1);
      wait_idle(1000);
      chk("reach_50", 32'(duty_cycle), 50);
      do_reset(2);
      send(12);
      wait_idle(1000);
      chk("no_overshoot", 32'(duty_cycle), 12);
      send(120);
      wait_idle(1000);
      chk("clamp_100", 32'(duty_cycle), 100);
      do_reset(1);
      send(100);
      wait_duty(30, 1000);
      send(10);
      wait_idle(1000);
      chk("retarget_10", 32'(duty_cycle), 10);
      send(60);
      wait_idle(1000);
      do_estop(4);
      repeat (30) @(negedge clk);
      chk("estop_stays_0", 32'(duty_cycle), 0);
      send(50);
      wait_duty(35, 1000);
      do_reset(1);
      chk("rst_mid_ramp", 32'(duty_cycle), 0);
      send(20);
      wait_idle(1000);
      chk("ramp_after_rst", 32'(duty_cycle), 20);
      for (int i = 0; i < 40; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) do_estop($urandom_range(0, 5));
         else if (r == 1) do_reset($urandom_range(1, 3));
         else begin
            send($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 1) wait_idle(1000);
            else repeat ($urandom_range(1, 200)) @(negedge clk);
         end
      end
      wait_idle(1000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
